uart_rx_os: RTL and testbench

- Parametrised successor to the existing fixed 8N1 UART receiver.
- Fully synchronous, single clock domain. Oversamples the line and majority-votes each bit.
- Supports configurable data width, parity and stop bits; reports framing, parity and overrun errors.
- Delivers each word to the consumer over a valid/ready handshake. Sits between the pad-side rx pin and the command/byte-stream logic.

---
 rtl/uart_rx_os.sv | 212 +++++++++++++++++++++
 tb/tb_uart_rx_os.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver: 2-flop synchroniser, majority-voted bit sampling,
// configurable width/parity/stop bits, valid/ready output with error flags.
module uart_rx_os #(
  parameter int CLKFREQ    = 12000000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 8,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  input  logic                 ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  // Handshake: a word is transferred on every cycle where valid && ready;
  // data and flags are held stable while valid is high.

  localparam int DIV_RAW = CLKFREQ / (BAUD * OVERSAMPLE);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int TW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int PW      = $clog2(OVERSAMPLE);
  localparam int IW      = $clog2(DATA_BITS + 1);

  localparam logic [TW-1:0] DIV_LAST = TW'(DIV - 1);
  localparam logic [PW-1:0] PH_LAST  = PW'(OVERSAMPLE - 1);
  localparam logic [PW-1:0] PH_A     = PW'(OVERSAMPLE / 2 - 1);
  localparam logic [PW-1:0] PH_B     = PW'(OVERSAMPLE / 2);
  localparam logic [PW-1:0] PH_MID   = PW'(OVERSAMPLE / 2 + 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t               state_q, state_d;
  logic                 meta_q, rs_q;
  logic [TW-1:0]        tick_cnt_q, tick_cnt_d;
  logic [PW-1:0]        phase_q, phase_d, phase_nxt;
  logic [IW-1:0]        idx_q, idx_d;
  logic                 stop2_q, stop2_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic [1:0]           vote_q, vote_d;
  logic                 perr_q, perr_d, ferr_q, ferr_d;
  logic                 done_q, done_d;
  logic                 guard_q, guard_d, hi_q, hi_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d, perr_o_q, perr_o_d;
  logic                 ferr_o_q, ferr_o_d, overrun_q, overrun_d;
  logic                 tick, mid, bit_val, par_exp, ferr_now;

  assign tick      = (tick_cnt_q == DIV_LAST);
  assign phase_nxt = (phase_q == PH_LAST) ? '0 : phase_q + 1'b1;
  assign mid       = tick && (phase_nxt == PH_MID);
  assign bit_val   = (vote_q[0] & vote_q[1]) | (vote_q[0] & rs_q) | (vote_q[1] & rs_q);
  assign par_exp   = (^shreg_q) ^ (PARITY == 1);
  assign ferr_now  = ferr_q | ~bit_val;

  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
    phase_d    = tick ? phase_nxt : phase_q;
    idx_d      = idx_q;
    stop2_d    = stop2_q;
    shreg_d    = shreg_q;
    vote_d     = vote_q;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    done_d     = 1'b0;
    guard_d    = guard_q;
    hi_d       = hi_q;
    if (tick && phase_nxt == PH_A) vote_d[0] = rs_q;
    if (tick && phase_nxt == PH_B) vote_d[1] = rs_q;
    case (state_q)
      S_IDLE: begin
        if (guard_q) begin
          // After a framing error the line must sit high for a full tick period.
          if (!rs_q) hi_d = 1'b0;
          else if (tick) begin
            if (hi_q) guard_d = 1'b0;
            hi_d = 1'b1;
          end
        end else if (!rs_q) begin
          state_d    = S_START;
          tick_cnt_d = '0;
          phase_d    = '0;
          perr_d     = 1'b0;
          ferr_d     = 1'b0;
        end
      end
      S_START: begin
        if (mid) begin
          if (bit_val) state_d = S_IDLE;
          else begin
            state_d = S_DATA;
            idx_d   = '0;
          end
        end
      end
      S_DATA: begin
        if (mid) begin
          shreg_d = {bit_val, shreg_q[DATA_BITS-1:1]};
          if (idx_q == IDX_LAST) begin
            state_d = (PARITY != 0) ? S_PARITY : S_STOP;
            stop2_d = 1'b0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      S_PARITY: begin
        if (mid) begin
          if (bit_val != par_exp) perr_d = 1'b1;
          state_d = S_STOP;
          stop2_d = 1'b0;
        end
      end
      S_STOP: begin
        if (mid) begin
          ferr_d = ferr_now;
          if (STOP_BITS == 2 && !stop2_q) stop2_d = 1'b1;
          else begin
            state_d = S_IDLE;
            done_d  = 1'b1;
            guard_d = ferr_now;
            hi_d    = 1'b0;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    data_d    = data_q;
    valid_d   = valid_q;
    perr_o_d  = perr_o_q;
    ferr_o_d  = ferr_o_q;
    overrun_d = overrun_q;
    if (valid_q && ready) begin
      valid_d   = 1'b0;
      overrun_d = 1'b0;
    end
    if (done_q) begin
      if (!valid_q || ready) begin
        data_d   = shreg_q;
        perr_o_d = perr_q;
        ferr_o_d = ferr_q;
        valid_d  = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q     <= 1'b1;
      rs_q       <= 1'b1;
      state_q    <= S_IDLE;
      tick_cnt_q <= '0;
      phase_q    <= '0;
      idx_q      <= '0;
      stop2_q    <= 1'b0;
      shreg_q    <= '0;
      vote_q     <= '0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      done_q     <= 1'b0;
      guard_q    <= 1'b0;
      hi_q       <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      perr_o_q   <= 1'b0;
      ferr_o_q   <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      meta_q     <= rx;
      rs_q       <= meta_q;
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      phase_q    <= phase_d;
      idx_q      <= idx_d;
      stop2_q    <= stop2_d;
      shreg_q    <= shreg_d;
      vote_q     <= vote_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      done_q     <= done_d;
      guard_q    <= guard_d;
      hi_q       <= hi_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      perr_o_q   <= perr_o_d;
      ferr_o_q   <= ferr_o_d;
      overrun_q  <= overrun_d;
    end
  end

  assign data       = data_q;
  assign valid      = valid_q;
  assign parity_err = perr_o_q;
  assign frame_err  = ferr_o_q;
  assign overrun    = overrun_q;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_os.sv
// Directed bench for uart_rx_os: three instances cover 8N1, 7E1 and 8N2 framing.
module tb_uart_rx_os;

  localparam int BIT = 104;  // clocks per bit at the default rate (DIV = 13)

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       rx0 = 1'b1, rdy0 = 1'b0, v0, pe0, fe0, ov0, bz0;
  logic [7:0] d0;
  logic       rx1 = 1'b1, rdy1 = 1'b0, v1, pe1, fe1, ov1, bz1;
  logic [6:0] d1;
  logic       rx2 = 1'b1, rdy2 = 1'b0, v2, pe2, fe2, ov2, bz2;
  logic [7:0] d2;

  int checks = 0;
  int errors = 0;

  uart_rx_os dut0 (
    .clk(clk), .rst(rst), .rx(rx0), .data(d0), .valid(v0), .ready(rdy0),
    .parity_err(pe0), .frame_err(fe0), .overrun(ov0), .busy(bz0)
  );

  uart_rx_os #(.DATA_BITS(7), .PARITY(2)) dut1 (
    .clk(clk), .rst(rst), .rx(rx1), .data(d1), .valid(v1), .ready(rdy1),
    .parity_err(pe1), .frame_err(fe1), .overrun(ov1), .busy(bz1)
  );

  uart_rx_os #(.STOP_BITS(2)) dut2 (
    .clk(clk), .rst(rst), .rx(rx2), .data(d2), .valid(v2), .ready(rdy2),
    .parity_err(pe2), .frame_err(fe2), .overrun(ov2), .busy(bz2)
  );

  // Accepted words, packed as {parity_err, frame_err, data zero-extended to 9}.
  logic [10:0] cap0_q[$];
  logic [10:0] cap1_q[$];
  logic [10:0] cap2_q[$];
  int   vhi0 = 0;
  int   v0_rise = 0;
  logic v0_prev = 1'b0;

  always @(negedge clk) begin
    if (v0) vhi0 <= vhi0 + 1;
    if (v0 && !v0_prev) v0_rise <= cyc;
    v0_prev <= v0;
    if (v0 && rdy0) cap0_q.push_back({pe0, fe0, 1'b0, d0});
  end

  always @(negedge clk) begin
    if (v1 && rdy1) cap1_q.push_back({pe1, fe1, 2'b00, d1});
  end

  always @(negedge clk) begin
    if (v2 && rdy2) cap2_q.push_back({pe2, fe2, 1'b0, d2});
  end

  // Drivers: called at a negedge; the line level holds for n clocks.
  task automatic hold(input int sel, input logic v, input int n);
    case (sel)
      0: rx0 = v;
      1: rx1 = v;
      default: rx2 = v;
    endcase
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input int sel, input logic [8:0] d, input int nbits,
                            input int par, input int nstop, input logic stop_val);
    hold(sel, 1'b0, BIT);
    for (int i = 0; i < nbits; i++) hold(sel, d[i], BIT);
    if (par >= 0) hold(sel, par[0], BIT);
    for (int i = 0; i < nstop; i++) hold(sel, stop_val, BIT);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (4) @(negedge clk);
    checks++; if ({d0, v0, pe0, fe0, ov0, bz0} !== 14'h0) begin
      errors++; $display("FAIL reset_dut0: got %h expected 0", {d0, v0, pe0, fe0, ov0, bz0});
    end
    checks++; if ({d1, v1, pe1, fe1, ov1, bz1} !== 12'h0) begin
      errors++; $display("FAIL reset_dut1: got %h expected 0", {d1, v1, pe1, fe1, ov1, bz1});
    end
    checks++; if ({d2, v2, pe2, fe2, ov2, bz2} !== 14'h0) begin
      errors++; $display("FAIL reset_dut2: got %h expected 0", {d2, v2, pe2, fe2, ov2, bz2});
    end
    rst = 1'b0;
    repeat (2 * BIT) @(negedge clk);
  endtask

  task automatic test_basic_8n1();
    int n, h, t0;
    logic [10:0] e;
    rdy0 = 1'b1;
    n = cap0_q.size();
    h = vhi0;
    @(negedge clk);
    t0 = cyc;
    send_frame(0, 9'h0A5, 8, -1, 1, 1'b1);
    hold(0, 1'b1, 2 * BIT);
    e = (cap0_q.size() > n) ? cap0_q[n] : 11'h7FF;
    checks++; if (cap0_q.size() !== n + 1) begin
      errors++; $display("FAIL basic_count: got %0d expected %0d", cap0_q.size() - n, 1);
    end
    checks++; if (e[8:0] !== 9'h0A5) begin
      errors++; $display("FAIL basic_data: got %h expected a5", e[8:0]);
    end
    checks++; if (e[10:9] !== 2'b00) begin
      errors++; $display("FAIL basic_flags: got %b expected 00", e[10:9]);
    end
    checks++; if (vhi0 - h !== 1) begin
      errors++; $display("FAIL basic_pulse_len: got %0d expected 1", vhi0 - h);
    end
    checks++; if (v0_rise - t0 < 995 || v0_rise - t0 > 1015) begin
      errors++; $display("FAIL basic_latency: got %0d expected 995..1015", v0_rise - t0);
    end
  endtask

  task automatic test_false_start();
    int h;
    @(negedge clk);
    h = vhi0;
    rx0 = 1'b0;
    repeat (10) @(negedge clk);
    checks++; if (bz0 !== 1'b1) begin
      errors++; $display("FAIL glitch_busy_high: got %b expected 1", bz0);
    end
    repeat (20) @(negedge clk);
    rx0 = 1'b1;
    repeat (50) @(negedge clk);
    checks++; if (bz0 !== 1'b0) begin
      errors++; $display("FAIL glitch_busy_low: got %b expected 0", bz0);
    end
    repeat (2 * BIT) @(negedge clk);
    checks++; if (vhi0 !== h) begin
      errors++; $display("FAIL glitch_no_valid: got %0d valid cycles expected 0", vhi0 - h);
    end
  endtask

  task automatic test_parity();
    int n;
    logic [10:0] e0, e1;
    rdy1 = 1'b1;
    n = cap1_q.size();
    @(negedge clk);
    send_frame(1, 9'h041, 7, 0, 1, 1'b1);
    hold(1, 1'b1, BIT);
    send_frame(1, 9'h041, 7, 1, 1, 1'b1);
    hold(1, 1'b1, 2 * BIT);
    e0 = (cap1_q.size() > n) ? cap1_q[n] : 11'h7FF;
    e1 = (cap1_q.size() > n + 1) ? cap1_q[n+1] : 11'h7FF;
    checks++; if (cap1_q.size() !== n + 2) begin
      errors++; $display("FAIL par_count: got %0d expected 2", cap1_q.size() - n);
    end
    checks++; if (e0[8:0] !== 9'h041 || e0[10] !== 1'b0) begin
      errors++; $display("FAIL par_good: got data %h perr %b expected 41 / 0", e0[8:0], e0[10]);
    end
    checks++; if (e1[8:0] !== 9'h041) begin
      errors++; $display("FAIL par_bad_data: got %h expected 41", e1[8:0]);
    end
    checks++; if (e1[10] !== 1'b1) begin
      errors++; $display("FAIL par_bad_flag: got %b expected 1", e1[10]);
    end
    checks++; if (e1[9] !== 1'b0) begin
      errors++; $display("FAIL par_bad_ferr: got %b expected 0", e1[9]);
    end
  endtask

  task automatic test_frame_break();
    int n;
    logic [10:0] e0, e1;
    rdy0 = 1'b1;
    n = cap0_q.size();
    @(negedge clk);
    send_frame(0, 9'h03C, 8, -1, 1, 1'b0);
    hold(0, 1'b0, 3 * BIT);
    hold(0, 1'b1, 2 * BIT);
    send_frame(0, 9'h05A, 8, -1, 1, 1'b1);
    hold(0, 1'b1, 2 * BIT);
    e0 = (cap0_q.size() > n) ? cap0_q[n] : 11'h7FF;
    e1 = (cap0_q.size() > n + 1) ? cap0_q[n+1] : 11'h7FF;
    checks++; if (cap0_q.size() !== n + 2) begin
      errors++; $display("FAIL brk_count: got %0d expected 2", cap0_q.size() - n);
    end
    checks++; if (e0[8:0] !== 9'h03C || e0[9] !== 1'b1) begin
      errors++; $display("FAIL brk_first: got data %h ferr %b expected 3c / 1", e0[8:0], e0[9]);
    end
    checks++; if (e1[8:0] !== 9'h05A) begin
      errors++; $display("FAIL brk_next_data: got %h expected 5a", e1[8:0]);
    end
    checks++; if (e1[10:9] !== 2'b00) begin
      errors++; $display("FAIL brk_next_flags: got %b expected 00", e1[10:9]);
    end
  endtask

  task automatic test_back_to_back_overrun();
    int n;
    logic [10:0] e;
    rdy0 = 1'b0;
    n = cap0_q.size();
    @(negedge clk);
    send_frame(0, 9'h011, 8, -1, 1, 1'b1);
    send_frame(0, 9'h022, 8, -1, 1, 1'b1);
    send_frame(0, 9'h033, 8, -1, 1, 1'b1);
    hold(0, 1'b1, 2 * BIT);
    checks++; if (v0 !== 1'b1) begin
      errors++; $display("FAIL ovr_valid_held: got %b expected 1", v0);
    end
    checks++; if (d0 !== 8'h11) begin
      errors++; $display("FAIL ovr_data_kept: got %h expected 11", d0);
    end
    checks++; if (ov0 !== 1'b1) begin
      errors++; $display("FAIL ovr_flag: got %b expected 1", ov0);
    end
    rdy0 = 1'b1;
    @(negedge clk);
    rdy0 = 1'b0;
    e = (cap0_q.size() > n) ? cap0_q[n] : 11'h7FF;
    checks++; if (v0 !== 1'b0) begin
      errors++; $display("FAIL ovr_valid_fall: got %b expected 0", v0);
    end
    checks++; if (ov0 !== 1'b0) begin
      errors++; $display("FAIL ovr_clear: got %b expected 0", ov0);
    end
    checks++; if (e[8:0] !== 9'h011) begin
      errors++; $display("FAIL ovr_accepted_word: got %h expected 11", e[8:0]);
    end
  endtask

  task automatic test_reset_midframe();
    int n;
    logic [10:0] e;
    rdy2 = 1'b0;
    @(negedge clk);
    send_frame(2, 9'h033, 8, -1, 2, 1'b1);
    hold(2, 1'b1, BIT);
    checks++; if (v2 !== 1'b1 || d2 !== 8'h33) begin
      errors++; $display("FAIL rmf_pre_word: got valid %b data %h expected 1 / 33", v2, d2);
    end
    hold(2, 1'b0, 5 * BIT);      // start bit plus data bits 0..3
    hold(2, 1'b1, BIT / 2);      // halfway into bit 4
    checks++; if (bz2 !== 1'b1) begin
      errors++; $display("FAIL rmf_busy_before: got %b expected 1", bz2);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++; if ({d2, v2, pe2, fe2, ov2, bz2} !== 14'h0) begin
      errors++; $display("FAIL rmf_outputs_cleared: got %h expected 0", {d2, v2, pe2, fe2, ov2, bz2});
    end
    rst = 1'b0;
    hold(2, 1'b1, 3 * BIT);
    checks++; if (v2 !== 1'b0 || bz2 !== 1'b0) begin
      errors++; $display("FAIL rmf_no_partial: got valid %b busy %b expected 0 / 0", v2, bz2);
    end
    rdy2 = 1'b1;
    n = cap2_q.size();
    send_frame(2, 9'h07E, 8, -1, 2, 1'b1);
    hold(2, 1'b1, 2 * BIT);
    e = (cap2_q.size() > n) ? cap2_q[n] : 11'h7FF;
    checks++; if (cap2_q.size() !== n + 1) begin
      errors++; $display("FAIL rmf_count: got %0d expected 1", cap2_q.size() - n);
    end
    checks++; if (e[8:0] !== 9'h07E) begin
      errors++; $display("FAIL rmf_data: got %h expected 7e", e[8:0]);
    end
    checks++; if (e[10:9] !== 2'b00) begin
      errors++; $display("FAIL rmf_flags: got %b expected 00", e[10:9]);
    end
  endtask

  initial begin
    test_reset();
    test_basic_8n1();
    test_false_start();
    test_parity();
    test_frame_break();
    test_back_to_back_overrun();
    test_reset_midframe();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
